issue_queue_param: RTL

ISSUE_QUEUE_PARAM -- requirements
Module: issue_queue_param

---
 rtl/issue_queue_param_pkg.sv | 45 ++++
 rtl/issue_queue_param_slot.sv | 63 ++++++
 rtl/issue_queue_param.sv | 137 +++++++++++++
 3 files changed

// File: rtl/issue_queue_param_pkg.sv
// rtl/issue_queue_param_pkg.sv - shared micro-op types and sizing constants for the issue queue
package issue_queue_param_pkg;

   localparam int PRF_INDEX_SIZE = 6;
   localparam int IQ_FP_SIZE     = 16;
   localparam int DISPATCH_WIDTH = 4;
   localparam int ISSUE_WIDTH_FP = 2;

   typedef enum logic [1:0] {
      RS_FROM_RF   = 2'd0,
      RS_FROM_IMM  = 2'd1,
      RS_FROM_PC   = 2'd2,
      RS_FROM_ZERO = 2'd3
   } rs_source_t;

   typedef struct packed {
      logic                      valid;
      logic [7:0]                tag;
      rs_source_t                rs1_source;
      logic [PRF_INDEX_SIZE-1:0] rs1_prf_index;
      rs_source_t                rs2_source;
      logic [PRF_INDEX_SIZE-1:0] rs2_prf_index;
      rs_source_t                rs3_source;
      logic [PRF_INDEX_SIZE-1:0] rs3_prf_index;
      logic [PRF_INDEX_SIZE-1:0] rd_prf_index;
   } micro_op_t;

   // Source n (0-based) maps onto the rs1..rs3 fields.
   function automatic rs_source_t src_kind(micro_op_t u, int n);
      case (n)
         0:       return u.rs1_source;
         1:       return u.rs2_source;
         default: return u.rs3_source;
      endcase
   endfunction

   function automatic logic [PRF_INDEX_SIZE-1:0] src_prf(micro_op_t u, int n);
      case (n)
         0:       return u.rs1_prf_index;
         1:       return u.rs2_prf_index;
         default: return u.rs3_prf_index;
      endcase
   endfunction

endpackage

// File: rtl/issue_queue_param_slot.sv
// rtl/issue_queue_param_slot.sv - one issue slot: uop storage, source lookup index and readiness
module issue_slot_param
   import issue_queue_param_pkg::*;
#(
   parameter int NSRC = 3
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 clear_i,
   input  logic                                 load_i,
   input  micro_op_t                            uop_i,
   input  logic                                 issue_i,
   input  logic [NSRC-1:0]                      src_busy_i,
   output micro_op_t                            uop_o,
   output logic                                 valid_o,
   output logic                                 ready_o,
   output logic [NSRC-1:0][PRF_INDEX_SIZE-1:0] src_index_o
);

   micro_op_t uop_q, uop_d;
   logic      valid_q, valid_d;

   // A slot is only ever loaded while empty, so load and issue never coincide.
   always_comb begin
      uop_d   = uop_q;
      valid_d = valid_q;
      if (load_i) begin
         uop_d   = uop_i;
         valid_d = 1'b1;
      end else if (issue_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || clear_i) begin
         uop_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         uop_q   <= uop_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      ready_o = valid_q;
      for (int n = 0; n < NSRC; n++) begin
         if (valid_q && src_kind(uop_q, n) == RS_FROM_RF) begin
            src_index_o[n] = src_prf(uop_q, n);
         end else begin
            src_index_o[n] = '0;
         end
         if (src_kind(uop_q, n) == RS_FROM_RF && src_busy_i[n]) begin
            ready_o = 1'b0;
         end
      end
      uop_o       = uop_q;
      uop_o.valid = valid_q;
   end

   assign valid_o = valid_q;

endmodule

// File: rtl/issue_queue_param.sv
// rtl/issue_queue_param.sv - age-matrix issue queue with compacting dispatch and oldest-first multi-port issue
module issue_queue_param
   import issue_queue_param_pkg::*;
#(
   parameter int DEPTH     = IQ_FP_SIZE,
   parameter int IN_WIDTH  = DISPATCH_WIDTH,
   parameter int OUT_WIDTH = ISSUE_WIDTH_FP,
   parameter int NSRC      = 3
) (
   input  logic                                            clock,
   input  logic                                            reset,
   input  logic                                            clear_en,
   input  logic                                            load_en,
   input  micro_op_t [IN_WIDTH-1:0]                        uop_in,
   output logic [DEPTH-1:0][NSRC-1:0][PRF_INDEX_SIZE-1:0] src_index,
   input  logic [DEPTH-1:0][NSRC-1:0]                      src_busy,
   input  logic [OUT_WIDTH-1:0]                            ex_busy,
   output micro_op_t [OUT_WIDTH-1:0]                       uop_out,
   output logic [$clog2(OUT_WIDTH):0]                      issue_count,
   output logic                                            iq_full
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(OUT_WIDTH) + 1;

   logic [CW-1:0]                  free_count_q, free_count_d;
   logic [DEPTH-1:0][DEPTH-1:0]    older_q, older_d;
   logic [DEPTH-1:0]               slot_valid, slot_ready, load_sel, issue_sel;
   micro_op_t [DEPTH-1:0]          slot_uop, load_uop;
   logic [IN_WIDTH-1:0][CW-1:0]    lane_rank;
   logic [DEPTH-1:0][CW-1:0]       ready_rank;
   logic [OUT_WIDTH-1:0][CW-1:0]   port_rank;
   logic [CW-1:0]                  lane_count, accept_count, free_rank, avail_count;
   logic                           accept;

   assign iq_full      = free_count_q < CW'(IN_WIDTH);
   assign accept       = load_en & ~iq_full;
   assign accept_count = accept ? lane_count : '0;

   // The n-th valid lane lands in the n-th lowest-index free slot.
   always_comb begin
      lane_count = '0;
      free_rank  = '0;
      load_sel   = '0;
      load_uop   = '0;
      for (int l = 0; l < IN_WIDTH; l++) begin
         lane_rank[l] = lane_count;
         if (uop_in[l].valid) lane_count = lane_count + CW'(1);
      end
      for (int s = 0; s < DEPTH; s++) begin
         if (!slot_valid[s]) begin
            for (int l = 0; l < IN_WIDTH; l++) begin
               if (accept && uop_in[l].valid && lane_rank[l] == free_rank) begin
                  load_sel[s] = 1'b1;
                  load_uop[s] = uop_in[l];
               end
            end
            free_rank = free_rank + CW'(1);
         end
      end
   end

   // older_q[j][s] set means slot j is older than slot s. Same-cycle loads
   // fill ascending slots in lane order, so a lower loaded slot is older.
   always_comb begin
      older_d = older_q;
      for (int s = 0; s < DEPTH; s++) begin
         if (load_sel[s]) older_d[s] = '0;
      end
      for (int s = 0; s < DEPTH; s++) begin
         if (load_sel[s]) begin
            for (int j = 0; j < DEPTH; j++) begin
               older_d[j][s] = slot_valid[j] | (load_sel[j] & (j < s));
            end
         end
      end
   end

   // Rank each ready slot by how many ready slots are older, then hand
   // rank k to the k-th non-busy port.
   always_comb begin
      avail_count = '0;
      issue_count = '0;
      issue_sel   = '0;
      uop_out     = '0;
      for (int s = 0; s < DEPTH; s++) begin
         ready_rank[s] = '0;
         for (int j = 0; j < DEPTH; j++) begin
            if (slot_ready[j] && older_q[j][s]) ready_rank[s] = ready_rank[s] + CW'(1);
         end
      end
      for (int p = 0; p < OUT_WIDTH; p++) begin
         port_rank[p] = avail_count;
         if (!ex_busy[p]) avail_count = avail_count + CW'(1);
      end
      for (int p = 0; p < OUT_WIDTH; p++) begin
         if (!ex_busy[p]) begin
            for (int s = 0; s < DEPTH; s++) begin
               if (slot_ready[s] && ready_rank[s] == port_rank[p]) begin
                  uop_out[p]   = slot_uop[s];
                  issue_sel[s] = 1'b1;
                  issue_count  = issue_count + IW'(1);
               end
            end
         end
      end
   end

   assign free_count_d = free_count_q - accept_count + CW'(issue_count);

   always_ff @(posedge clock) begin
      if (reset || clear_en) begin
         free_count_q <= CW'(DEPTH);
         older_q      <= '0;
      end else begin
         free_count_q <= free_count_d;
         older_q      <= older_d;
      end
   end

   for (genvar s = 0; s < DEPTH; s++) begin : g_slot
      issue_slot_param #(.NSRC(NSRC)) u_slot (
         .clock       (clock),
         .reset       (reset),
         .clear_i     (clear_en),
         .load_i      (load_sel[s]),
         .uop_i       (load_uop[s]),
         .issue_i     (issue_sel[s]),
         .src_busy_i  (src_busy[s]),
         .uop_o       (slot_uop[s]),
         .valid_o     (slot_valid[s]),
         .ready_o     (slot_ready[s]),
         .src_index_o (src_index[s])
      );
   end

endmodule
